// File: rtl/m68k_bus_responder_if.sv
// 68000 CPU bus strobes plus the single-outstanding memory request/ack port.
// The responder uses the slave modport; the CPU/memory side uses master.
interface m68k_bus_responder_if;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        rw_n;
  logic [23:0] address;
  logic [2:0]  FC;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        DTACK_n;
  logic        VPA_n;
  logic        BERR_n;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [22:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport slave (
    input  AS_n, UDS_n, LDS_n, rw_n, address, FC, cpu_dout, mem_ack, mem_rdata,
    output cpu_din, DTACK_n, VPA_n, BERR_n, mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output AS_n, UDS_n, LDS_n, rw_n, address, FC, cpu_dout, mem_ack, mem_rdata,
    input  cpu_din, DTACK_n, VPA_n, BERR_n, mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/m68k_bus_responder.sv
// Answers 68000 bus cycles from a level mem_req / pulse mem_ack memory port.
// DTACK_n asserts 1+WAIT_STATES cycles after mem_ack; no mem_ack within TIMEOUT cycles gives BERR_n.
module m68k_bus_responder #(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 255
) (
  input logic                 clk,
  input logic                 reset_n,
  m68k_bus_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, IACK, BERR, DRAIN} state_t;

  localparam int            WW      = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WW-1:0] WS_LAST = WW'(WAIT_STATES - 1);
  localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    tcnt;
  logic [WW-1:0] wcnt;
  logic          armed;
  logic          dtack_n, vpa_n, berr_n;
  logic          mem_req, mem_we;
  logic [1:0]    mem_be;
  logic [22:0]   mem_addr;
  logic [15:0]   mem_wdata, cpu_din;

  wire unused_addr_lsb = bus.address[0];

  // armed records that AS_n has been seen high since the last accepted cycle,
  // so a new transaction needs a fresh AS_n falling edge (also after reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      wcnt      <= '0;
      armed     <= 1'b0;
      dtack_n   <= 1'b1;
      vpa_n     <= 1'b1;
      berr_n    <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_din   <= '0;
    end else begin
      if (bus.AS_n) armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (armed && !bus.AS_n) begin
            if (bus.FC == 3'b111) begin
              state <= IACK;
              vpa_n <= 1'b0;
              armed <= 1'b0;
            end else if (!bus.UDS_n || !bus.LDS_n) begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_addr  <= bus.address[23:1];
              mem_we    <= ~bus.rw_n;
              mem_be    <= {~bus.UDS_n, ~bus.LDS_n};
              mem_wdata <= bus.cpu_dout;
              tcnt      <= '0;
              armed     <= 1'b0;
            end
          end
        end
        REQ: begin
          if (bus.mem_ack && !bus.AS_n) begin
            mem_req <= 1'b0;
            if (!mem_we) cpu_din <= bus.mem_rdata;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              wcnt  <= '0;
            end else begin
              state   <= ACK;
              dtack_n <= 1'b0;
            end
          end else if (bus.mem_ack || (bus.AS_n && tcnt == TO_LAST)) begin
            // aborted cycle finishing in the same clock: drop quietly
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (bus.AS_n) begin
            state <= DRAIN;
            tcnt  <= tcnt + 8'd1;
          end else if (tcnt == TO_LAST) begin
            mem_req <= 1'b0;
            berr_n  <= 1'b0;
            state   <= BERR;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        WAIT: begin
          if (bus.AS_n) begin
            state <= IDLE;
          end else if (wcnt == WS_LAST) begin
            state   <= ACK;
            dtack_n <= 1'b0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ACK: begin
          if (bus.AS_n) begin
            dtack_n <= 1'b1;
            state   <= IDLE;
          end
        end
        IACK: begin
          if (bus.AS_n) begin
            vpa_n <= 1'b1;
            state <= IDLE;
          end
        end
        BERR: begin
          if (bus.AS_n) begin
            berr_n <= 1'b1;
            state  <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.mem_ack || tcnt == TO_LAST) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.DTACK_n   = dtack_n;
  assign bus.VPA_n     = vpa_n;
  assign bus.BERR_n    = berr_n;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_be    = mem_be;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_din   = cpu_din;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Drives two responders (WAIT_STATES 0 and 3) with identical bus traffic and checks
// both against per-transaction expectations; index 0 is the zero-wait instance.
module tb_m68k_bus_responder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        as_n, uds_n, lds_n, rw_n, mem_ack;
  logic [23:0] address;
  logic [2:0]  fc;
  logic [15:0] cpu_dout, mem_rdata;

  m68k_bus_responder_if b0 ();
  m68k_bus_responder_if b3 ();

  m68k_bus_responder #(.WAIT_STATES(0), .TIMEOUT(255)) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  m68k_bus_responder #(.WAIT_STATES(3), .TIMEOUT(255)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3));

  assign b0.AS_n = as_n;       assign b3.AS_n = as_n;
  assign b0.UDS_n = uds_n;     assign b3.UDS_n = uds_n;
  assign b0.LDS_n = lds_n;     assign b3.LDS_n = lds_n;
  assign b0.rw_n = rw_n;       assign b3.rw_n = rw_n;
  assign b0.address = address; assign b3.address = address;
  assign b0.FC = fc;           assign b3.FC = fc;
  assign b0.cpu_dout = cpu_dout;   assign b3.cpu_dout = cpu_dout;
  assign b0.mem_ack = mem_ack;     assign b3.mem_ack = mem_ack;
  assign b0.mem_rdata = mem_rdata; assign b3.mem_rdata = mem_rdata;

  logic [1:0]  dtack, vpa, berr, req, we;
  logic [1:0]  be [2];
  logic [22:0] maddr [2];
  logic [15:0] wdata [2];
  logic [15:0] din [2];
  assign dtack = {b3.DTACK_n, b0.DTACK_n};
  assign vpa   = {b3.VPA_n, b0.VPA_n};
  assign berr  = {b3.BERR_n, b0.BERR_n};
  assign req   = {b3.mem_req, b0.mem_req};
  assign we    = {b3.mem_we, b0.mem_we};
  assign be[0] = b0.mem_be;        assign be[1] = b3.mem_be;
  assign maddr[0] = b0.mem_addr;   assign maddr[1] = b3.mem_addr;
  assign wdata[0] = b0.mem_wdata;  assign wdata[1] = b3.mem_wdata;
  assign din[0] = b0.cpu_din;      assign din[1] = b3.cpu_din;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic [15:0] last_din = 16'h0000;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if ((!dtack[d] && !vpa[d]) || (!dtack[d] && !berr[d]) || (!vpa[d] && !berr[d])) viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dtack"}, 32'(dtack), 32'h3);
    chk({tag, "_vpa"},   32'(vpa),   32'h3);
    chk({tag, "_berr"},  32'(berr),  32'h3);
    chk({tag, "_req"},   32'(req),   32'h0);
    chk({tag, "_we"},    32'(we),    32'h0);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_be"},    32'(be[d]),    32'h0);
      chk({tag, "_addr"},  32'(maddr[d]), 32'h0);
      chk({tag, "_wdata"}, 32'(wdata[d]), 32'h0);
      chk({tag, "_din"},   32'(din[d]),   32'h0);
    end
  endtask

  task automatic idle_cycle();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    step();
  endtask

  task automatic start_cycle(input logic [23:0] a, input logic rw, input logic u, input logic l,
                             input logic [2:0] f, input logic [15:0] dout);
    address = a; rw_n = rw; uds_n = u; lds_n = l; fc = f; cpu_dout = dout; as_n = 1'b0;
    step();
  endtask

  task automatic mem_txn(input string nm, input logic [23:0] a, input logic rw, input logic u,
                         input logic l, input logic [2:0] f, input logic [15:0] dout,
                         input logic [15:0] rdata, input int dly, input int hold, input bit stray,
                         input logic [22:0] e_addr, input logic [1:0] e_be, input logic e_we,
                         input logic [15:0] e_din);
    int bad = 0;
    idle_cycle();
    start_cycle(a, rw, u, l, f, dout);
    chk({nm, "_req"}, 32'(req), 32'h3);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_addr"},  32'(maddr[d]), 32'(e_addr));
      chk({nm, "_be"},    32'(be[d]),    32'(e_be));
      chk({nm, "_we"},    32'(we[d]),    32'(e_we));
      chk({nm, "_wdata"}, 32'(wdata[d]), 32'(dout));
    end
    address = 24'($urandom); cpu_dout = 16'($urandom);
    for (int i = 0; i < dly; i++) begin
      step();
      if (req != 2'b11 || dtack != 2'b11 || berr != 2'b11) bad++;
    end
    chk({nm, "_req_hold"}, 32'(bad), 32'h0);
    chk({nm, "_addr_stable"}, 32'(maddr[0]), 32'(e_addr));
    chk({nm, "_wdata_stable"}, 32'(wdata[1]), 32'(dout));
    mem_ack = 1'b1; mem_rdata = rdata;
    step();
    mem_ack = 1'b0; mem_rdata = ~rdata;
    chk({nm, "_req_drop"}, 32'(req), 32'h0);
    chk({nm, "_dtack_ack"}, 32'(dtack), 32'h2);
    chk({nm, "_din0"}, 32'(din[0]), 32'(e_din));
    chk({nm, "_din3"}, 32'(din[1]), 32'(e_din));
    for (int w = 1; w <= 3; w++) begin
      if (stray && w == 1) mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk({nm, "_dtack_wait"}, 32'(dtack), (w == 3) ? 32'h0 : 32'h2);
    end
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (dtack != 2'b00) bad++;
    end
    chk({nm, "_dtack_hold"}, 32'(bad), 32'h0);
    chk({nm, "_din_held"}, 32'(din[1]), 32'(e_din));
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    step();
    chk({nm, "_dtack_release"}, 32'(dtack), 32'h3);
  endtask

  task automatic abort_txn(input string nm, input logic [23:0] a, input logic rw, input logic u,
                           input logic l, input int pre, input int post);
    int bad = 0;
    idle_cycle();
    start_cycle(a, rw, u, l, 3'd1, 16'($urandom));
    chk({nm, "_req"}, 32'(req), 32'h3);
    for (int i = 0; i < pre; i++) step();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    step();
    chk({nm, "_drain_req"}, 32'(req), 32'h3);
    for (int i = 0; i < post; i++) begin
      step();
      if (req != 2'b11 || dtack != 2'b11) bad++;
    end
    chk({nm, "_drain_hold"}, 32'(bad), 32'h0);
    mem_ack = 1'b1; mem_rdata = 16'($urandom);
    step();
    mem_ack = 1'b0;
    chk({nm, "_req_drop"}, 32'(req), 32'h0);
    chk({nm, "_no_dtack"}, 32'(dtack), 32'h3);
    chk({nm, "_no_berr"}, 32'(berr), 32'h3);
    chk({nm, "_din0"}, 32'(din[0]), 32'(last_din));
    chk({nm, "_din3"}, 32'(din[1]), 32'(last_din));
    step();
    chk({nm, "_no_dtack_after"}, 32'(dtack), 32'h3);
  endtask

  task automatic iack_txn(input string nm, input int hold);
    int bad = 0;
    idle_cycle();
    fc = 3'b111; as_n = 1'b0; lds_n = 1'($urandom); uds_n = 1'b1;
    step();
    chk({nm, "_vpa"}, 32'(vpa), 32'h0);
    chk({nm, "_req"}, 32'(req), 32'h0);
    chk({nm, "_dtack"}, 32'(dtack), 32'h3);
    for (int i = 0; i < hold; i++) begin
      step();
      if (vpa != 2'b00 || req != 2'b00) bad++;
    end
    chk({nm, "_vpa_hold"}, 32'(bad), 32'h0);
    as_n = 1'b1; lds_n = 1'b1;
    step();
    chk({nm, "_vpa_release"}, 32'(vpa), 32'h3);
    fc = 3'd5;
  endtask

  typedef struct {
    logic [23:0] a;
    logic        rw, u, l;
    logic [15:0] dout, rdata;
    int          dly, hold;
    logic [22:0] e_addr;
    logic [1:0]  e_be;
    logic        e_we;
    logic [15:0] e_din;
  } vec_t;

  vec_t vt [5];

  initial begin
    int bad, cnt, n;
    vt[0] = '{24'h123456, 1'b1, 1'b0, 1'b0, 16'h1111, 16'hBEEF, 0, 1, 23'h091A2B, 2'b11, 1'b0, 16'hBEEF};
    vt[1] = '{24'h000101, 1'b0, 1'b1, 1'b0, 16'h00A5, 16'h7777, 2, 0, 23'h000080, 2'b01, 1'b1, 16'hBEEF};
    vt[2] = '{24'hFFFFFE, 1'b1, 1'b0, 1'b1, 16'h2222, 16'h1234, 1, 2, 23'h7FFFFF, 2'b10, 1'b0, 16'h1234};
    vt[3] = '{24'h800000, 1'b0, 1'b0, 1'b0, 16'hCAFE, 16'h9999, 3, 1, 23'h400000, 2'b11, 1'b1, 16'h1234};
    vt[4] = '{24'h00000A, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h0000, 7, 0, 23'h000005, 2'b11, 1'b0, 16'h0000};

    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw_n = 1'b1; address = '0; fc = 3'd5;
    cpu_dout = '0; mem_ack = 1'b0; mem_rdata = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_reset("por");
    #10 reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      mem_txn($sformatf("vec%0d", i), vt[i].a, vt[i].rw, vt[i].u, vt[i].l, 3'd5, vt[i].dout,
              vt[i].rdata, vt[i].dly, vt[i].hold, (i == 2), vt[i].e_addr, vt[i].e_be,
              vt[i].e_we, vt[i].e_din);
    last_din = 16'h0000;

    // abort during REQ, ack arrives 5 cycles after AS_n rises
    abort_txn("abort", 24'h2468AC, 1'b1, 1'b0, 1'b0, 2, 4);
    iack_txn("iack", 3);

    // address-only phase must not start a cycle
    idle_cycle();
    fc = 3'd1; as_n = 1'b0;
    step(); step(); step();
    chk("addr_only_req", 32'(req), 32'h0);
    chk("addr_only_dtack", 32'(dtack), 32'h3);

    // no mem_ack: bus error after exactly 255 REQ cycles
    idle_cycle();
    start_cycle(24'h0F0F0E, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
    cnt = 0; n = 0; bad = 0;
    while (berr[0] == 1'b1 && n < 300) begin
      if (req[0]) cnt++;
      if (dtack != 2'b11) bad++;
      step();
      n++;
    end
    chk("to_req_cycles", 32'(cnt), 32'd255);
    chk("to_berr", 32'(berr), 32'h0);
    chk("to_req_drop", 32'(req), 32'h0);
    step(); step();
    if (dtack != 2'b11) bad++;
    chk("to_berr_hold", 32'(berr), 32'h0);
    chk("to_no_dtack", 32'(bad), 32'h0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    step();
    chk("to_berr_release", 32'(berr), 32'h3);
    chk("to_din", 32'(din[0]), 32'(last_din));

    // mem_ack in the very cycle the timeout expires wins
    mem_txn("ack_at_timeout", 24'h00ABCD, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0, 16'h4242, 254, 0, 1'b0,
            23'h0055E6, 2'b11, 1'b0, 16'h4242);
    last_din = 16'h4242;

    // AS_n rises during the wait states: the waited responder never asserts DTACK_n
    idle_cycle();
    start_cycle(24'h000200, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
    mem_ack = 1'b1; mem_rdata = 16'h6B6B;
    step();
    mem_ack = 1'b0;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    step();
    chk("wait_abort_dtack", 32'(dtack), 32'h3);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dtack[1] != 1'b1) bad++;
    end
    chk("wait_abort_no_dtack", 32'(bad), 32'h0);
    chk("wait_abort_din", 32'(din[1]), 32'h6B6B);
    last_din = 16'h6B6B;

    // reset during WAIT, with AS_n still low across release
    idle_cycle();
    start_cycle(24'h001000, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    step();
    mem_ack = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1 chk_reset("wait_rst");
    step();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (req != 2'b00 || dtack != 2'b11) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'h0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    step();
    last_din = 16'h0000;

    for (int it = 0; it < 40; it++) begin
      int kind, pat;
      logic [23:0] a;
      logic rw, u, l;
      logic [15:0] dout, rdata, e_din;
      kind = $urandom_range(0, 9);
      a = 24'($urandom);
      rw = 1'($urandom);
      pat = $urandom_range(0, 2);
      u = (pat == 2); l = (pat == 1);
      dout = 16'($urandom);
      rdata = 16'($urandom);
      if (kind <= 6) begin
        e_din = rw ? rdata : last_din;
        mem_txn($sformatf("rnd%0d", it), a, rw, u, l, 3'($urandom_range(0, 6)), dout, rdata,
                $urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom),
                23'(a / 2), {~u, ~l}, ~rw, e_din);
        last_din = e_din;
      end else if (kind <= 8) begin
        abort_txn($sformatf("rnd%0d_abort", it), a, rw, u, l, $urandom_range(0, 5),
                  $urandom_range(0, 8));
      end else begin
        iack_txn($sformatf("rnd%0d_iack", it), $urandom_range(0, 4));
      end
    end

    chk("strobe_exclusive", 32'(viol), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
